// File: rtl/iob_eth_rx.sv
// MII receive engine: strips preamble/SFD, assembles nibbles into buffer bytes,
// checks CRC-32 at end of frame and holds a frame report until acknowledged.
module iob_eth_rx #(
    parameter int BUF_AW = 11
) (
    input  logic              RX_CLK,
    input  logic              rst,
    input  logic              RX_DV,
    input  logic              RX_ER,
    input  logic [3:0]        RX_DATA,
    output logic              wr,
    output logic [BUF_AW-1:0] addr,
    output logic [7:0]        data,
    output logic              received,
    output logic [BUF_AW-1:0] nbytes,
    output logic              rx_err,
    input  logic              rcv_ack
);

    localparam logic [31:0]       CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0]       CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0]       CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [BUF_AW-1:0] CNT_MAX     = {BUF_AW{1'b1}};
    localparam logic [BUF_AW-1:0] MIN_BYTES   = BUF_AW'(32'd4);

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        PREAMBLE  = 3'd2,
        DATA      = 3'd3,
        DONE      = 3'd4
    } state_t;

    // Reflected CRC-32 over one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if ((c[0] ^ d[i]) == 1'b1) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    state_t            state_r;
    logic [BUF_AW-1:0] cnt_r;
    logic [3:0]        low_r;
    logic              phase_r;
    logic              err_r;
    logic              full_r;
    logic [31:0]       crc_r;
    logic [7:0]        byte_s;
    logic [31:0]       crc_next_s;

    // Byte completed by the current high nibble and its CRC update.
    always_comb begin
        byte_s     = {RX_DATA, low_r};
        crc_next_s = crc32_byte(crc_r, byte_s);
    end

    // Receive state machine with registered buffer and report outputs.
    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            state_r  <= WAIT_IDLE;
            cnt_r    <= '0;
            low_r    <= 4'h0;
            phase_r  <= 1'b0;
            err_r    <= 1'b0;
            full_r   <= 1'b0;
            crc_r    <= CRC_INIT;
            wr       <= 1'b0;
            addr     <= '0;
            data     <= 8'h00;
            received <= 1'b0;
            nbytes   <= '0;
            rx_err   <= 1'b0;
        end else begin
            wr <= 1'b0;
            case (state_r)
                WAIT_IDLE: begin
                    if (!RX_DV) begin
                        state_r <= IDLE;
                    end
                end
                IDLE: begin
                    if (RX_DV && (RX_DATA == 4'h5)) begin
                        state_r <= PREAMBLE;
                    end
                end
                PREAMBLE: begin
                    if (!RX_DV) begin
                        state_r <= IDLE;
                    end else if (RX_DATA == 4'h5) begin
                        state_r <= PREAMBLE;
                    end else if (RX_DATA == 4'hD) begin
                        state_r <= DATA;
                        cnt_r   <= '0;
                        phase_r <= 1'b0;
                        crc_r   <= CRC_INIT;
                        err_r   <= 1'b0;
                        full_r  <= 1'b0;
                    end else begin
                        state_r <= WAIT_IDLE;
                    end
                end
                DATA: begin
                    if (!RX_DV) begin
                        state_r  <= DONE;
                        received <= 1'b1;
                        nbytes   <= cnt_r;
                        rx_err   <= err_r | phase_r | (cnt_r < MIN_BYTES) | (crc_r != CRC_RESIDUE);
                    end else begin
                        if (RX_ER) begin
                            err_r <= 1'b1;
                        end
                        if (!phase_r) begin
                            low_r   <= RX_DATA;
                            phase_r <= 1'b1;
                        end else begin
                            phase_r <= 1'b0;
                            // Once the last buffer slot is used, further bytes are dropped.
                            if (!full_r) begin
                                wr    <= 1'b1;
                                addr  <= cnt_r;
                                data  <= byte_s;
                                crc_r <= crc_next_s;
                                if (cnt_r == CNT_MAX) begin
                                    full_r <= 1'b1;
                                    err_r  <= 1'b1;
                                end else begin
                                    cnt_r <= cnt_r + BUF_AW'(32'd1);
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    if (rcv_ack) begin
                        received <= 1'b0;
                        state_r  <= RX_DV ? WAIT_IDLE : IDLE;
                    end
                end
                default: begin
                    state_r <= WAIT_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob_eth_rx.sv
// Directed, table-driven bench for iob_eth_rx: MII frames in, buffer writes and
// frame report checked against bench-computed frames and expected reports.
module tb_iob_eth_rx;

    logic        RX_CLK = 1'b0;
    logic        rst = 1'b1;
    logic        RX_DV = 1'b0;
    logic        RX_ER = 1'b0;
    logic [3:0]  RX_DATA = 4'h0;
    logic        wr;
    logic [10:0] addr;
    logic [7:0]  data;
    logic        received;
    logic [10:0] nbytes;
    logic        rx_err;
    logic        rcv_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] fb [0:2099];
    logic [7:0] mem [0:2047];
    bit         wrote [0:2047];
    int         wr_cnt = 0;

    typedef struct {
        string name;
        int    len;
        int    flip;
        bit    odd;
        int    er_idx;
        int    exp_writes;
        int    exp_nbytes;
        bit    exp_err;
    } vec_t;

    vec_t vecs [5];

    iob_eth_rx #(.BUF_AW(11)) dut (
        .RX_CLK  (RX_CLK),
        .rst     (rst),
        .RX_DV   (RX_DV),
        .RX_ER   (RX_ER),
        .RX_DATA (RX_DATA),
        .wr      (wr),
        .addr    (addr),
        .data    (data),
        .received(received),
        .nbytes  (nbytes),
        .rx_err  (rx_err),
        .rcv_ack (rcv_ack)
    );

    always #5 RX_CLK = ~RX_CLK;

    // Record every buffer write away from the active edge.
    always @(negedge RX_CLK) begin
        if (wr === 1'b1) begin
            wr_cnt++;
            mem[addr] = data;
            wrote[addr] = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_crc(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h000000, d};
        repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    task automatic clear_mon();
        wr_cnt = 0;
        for (int i = 0; i < 2048; i++) begin
            wrote[i] = 1'b0;
            mem[i] = 8'h00;
        end
    endtask

    task automatic cyc();
        @(posedge RX_CLK);
        #1;
    endtask

    task automatic nib(input logic [3:0] n, input logic er);
        RX_DV = 1'b1;
        RX_DATA = n;
        RX_ER = er;
        cyc();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr"}, wr, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_data"}, data, 0);
        check({tag, "_received"}, received, 0);
        check({tag, "_nbytes"}, nbytes, 0);
        check({tag, "_rx_err"}, rx_err, 0);
    endtask

    // Build frame bytes (payload i[7:0], then FCS), send preamble+SFD+nibbles, drop RX_DV.
    task automatic send_frame(input int len, input int flip, input bit odd,
                              input int er_idx, input int ack_idx, input int rst_idx);
        logic [31:0] crc;
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < len - 4; i++) begin
            fb[i] = i[7:0];
            crc = ref_crc(crc, fb[i]);
        end
        crc = ~crc;
        fb[len-4] = crc[7:0];
        fb[len-3] = crc[15:8];
        fb[len-2] = crc[23:16];
        fb[len-1] = crc[31:24];
        if (flip >= 0) fb[flip] = fb[flip] ^ 8'h01;
        repeat (15) nib(4'h5, 1'b0);
        nib(4'hD, 1'b0);
        for (int i = 0; i < len; i++) begin
            if (i == ack_idx) check("held_nbytes", nbytes, 64);
            rst = (i == rst_idx);
            rcv_ack = (i == ack_idx);
            nib(fb[i][3:0], i == er_idx);
            rst = 1'b0;
            rcv_ack = 1'b0;
            if (i == ack_idx) check("ack_mid_received", received, 0);
            if (i == rst_idx) check_reset_outputs("mid_rst");
            nib(fb[i][7:4], 1'b0);
        end
        if (odd) nib(4'hA, 1'b0);
        RX_DV = 1'b0;
        RX_ER = 1'b0;
        RX_DATA = 4'h0;
        cyc();
    endtask

    task automatic check_report(input string name, input int wexp, input int nexp, input bit eexp);
        int bad;
        bad = 0;
        for (int i = 0; i < wexp; i++) begin
            if (!wrote[i] || (mem[i] != fb[i])) bad++;
        end
        check({name, "_writes"}, wr_cnt, wexp);
        check({name, "_bad_bytes"}, bad, 0);
        check({name, "_received"}, received, 1);
        check({name, "_nbytes"}, nbytes, nexp);
        check({name, "_rx_err"}, rx_err, eexp);
        cyc();
        cyc();
        check({name, "_held_received"}, received, 1);
        check({name, "_held_nbytes"}, nbytes, nexp);
    endtask

    task automatic ack();
        rcv_ack = 1'b1;
        cyc();
        rcv_ack = 1'b0;
        check("ack_received", received, 0);
    endtask

    initial begin
        vecs[0] = '{"good",    64,   -1, 1'b0, -1, 64,   64,   1'b0};
        vecs[1] = '{"bad_crc", 64,   10, 1'b0, -1, 64,   64,   1'b1};
        vecs[2] = '{"odd_nib", 64,   -1, 1'b1, -1, 64,   64,   1'b1};
        vecs[3] = '{"rx_er",   64,   -1, 1'b0, 20, 64,   64,   1'b1};
        vecs[4] = '{"overflow", 2050, -1, 1'b0, -1, 2048, 2047, 1'b1};

        clear_mon();
        repeat (3) @(posedge RX_CLK);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        cyc();

        for (int v = 0; v < 5; v++) begin
            clear_mon();
            send_frame(vecs[v].len, vecs[v].flip, vecs[v].odd, vecs[v].er_idx, -1, -1);
            check_report(vecs[v].name, vecs[v].exp_writes, vecs[v].exp_nbytes, vecs[v].exp_err);
            ack();
        end

        // Frame arriving while a report is pending, acknowledged mid-frame.
        clear_mon();
        send_frame(64, -1, 1'b0, -1, -1, -1);
        check_report("pend_first", 64, 64, 1'b0);
        clear_mon();
        send_frame(64, -1, 1'b0, -1, 32, -1);
        check("pend_second_writes", wr_cnt, 0);
        check("pend_second_received", received, 0);
        clear_mon();
        send_frame(64, -1, 1'b0, -1, -1, -1);
        check_report("pend_third", 64, 64, 1'b0);
        ack();

        // Reset in the middle of a frame.
        clear_mon();
        send_frame(64, -1, 1'b0, -1, -1, 30);
        check("rst_frame_writes", wr_cnt, 30);
        check("rst_frame_received", received, 0);
        clear_mon();
        send_frame(64, -1, 1'b0, -1, -1, -1);
        check_report("after_rst", 64, 64, 1'b0);
        ack();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
